// File: rtl/riscv_pipe_controller.sv
// Purpose : D-stage decode of op/func3/func7 into the ID/EX (E-stage) control register,
//           with flush bubbles, illegal-opcode flagging and an M-extension latency sequencer.
// Latency : immSrcD is combinational; all *E outputs are registered (1 cycle after D).
//           M ops occupy E for MUL_LAT / DIV_LAT cycles.
// Backpressure: mdStall (combinational) is high while the sequencer holds E.
//           The hazard unit must stall F/D while it is high. flushE overrides the hold.
//
// Optional feature macro: MULDIV_EN
//   defined   -> M-extension decode and latency sequencer present
//   undefined -> op=0110011/func7=0000001 is illegal, mdStall tied 0,
//                ALU codes 1010/1011 never produced
//
// Ports:
//   clk, rst            core clock (rising edge); asynchronous active-low reset
//   op, func3, func7    instruction fields [6:0], [14:12], [31:25] in D
//   flushE              load a bubble into the E register (aborts in-flight M op)
//   immSrcD             immediate select: 000 I, 001 S, 010 B, 011 J, 100 U
//   regWriteE .. illegalE  registered E-stage control
//   mdStall             1 while the M-op sequencer holds E

module riscv_pipe_controller #(
    parameter int ALUC_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        op,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic              flushE,
    output logic [2:0]        immSrcD,
    output logic              regWriteE,
    output logic              memWriteE,
    output logic              ALUSrcE,
    output logic [1:0]        resultSrcE,
    output logic [1:0]        jumpE,
    output logic [2:0]        branchE,
    output logic              branchValidE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              illegalE,
    output logic              mdStall
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (ALUC_W < 4) begin : g_chk_aluc_w
        $error("riscv_pipe_controller: ALUC_W must be >= 4");
    end
    if (MUL_LAT < 1) begin : g_chk_mul_lat
        $error("riscv_pipe_controller: MUL_LAT must be >= 1");
    end
    if (DIV_LAT < 1) begin : g_chk_div_lat
        $error("riscv_pipe_controller: DIV_LAT must be >= 1");
    end

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef MULDIV_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
`ifdef MULDIV_EN
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
`endif

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    // Everything that travels through the E register. An all-zero value is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic [1:0] jump;
        logic [2:0] branch;
        logic       branch_valid;
        logic [3:0] alu;
        logic       illegal;
    } ctrl_t;

    // func3 -> ALU code; alt selects sub/sra (func7[5]) on the two codes that have one.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        code = ALU_ADD;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // D-stage decode
    // ------------------------------------------------------------------
    ctrl_t dec;
    logic  md_busy;
`ifdef MULDIV_EN
    logic  dec_md;
`endif

    always_comb begin
        dec     = '0;
        immSrcD = IMM_I;
`ifdef MULDIV_EN
        dec_md  = 1'b0;
`endif
        case (op)
            OP_R: begin
                dec.reg_write = 1'b1;
                case (func7)
                    F7_BASE: dec.alu = alu_from_f3(func3, 1'b0);
                    F7_ALT: begin
                        if (func3 == 3'b000 || func3 == 3'b101) begin
                            dec.alu = alu_from_f3(func3, 1'b1);
                        end else begin
                            dec         = '0;
                            dec.illegal = 1'b1;
                        end
                    end
`ifdef MULDIV_EN
                    F7_MULDIV: begin
                        dec.alu    = func3[2] ? ALU_DIV : ALU_MUL;
                        // The M-unit needs the exact variant; it rides in the branch field.
                        dec.branch = func3;
                        dec_md     = 1'b1;
                    end
`endif
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_I_ALU: begin
                // func7[5] is part of the immediate except for srli/srai.
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = alu_from_f3(func3, (func3 == 3'b101) && func7[5]);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                dec.alu        = ALU_ADD;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = ALU_ADD;
                immSrcD       = IMM_S;
            end
            OP_BRANCH: begin
                dec.branch_valid = 1'b1;
                dec.branch       = func3;
                dec.alu          = ALU_SUB;
                immSrcD          = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = JMP_JAL;
                dec.result_src = RES_PC4;
                immSrcD        = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = JMP_JALR;
                dec.result_src = RES_PC4;
                dec.alu_src    = 1'b1;
                dec.alu        = ALU_ADD;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_IMM;
                immSrcD        = IMM_U;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // E-stage control register: flush > sequencer hold > load
    // ------------------------------------------------------------------
    ctrl_t e_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
        end else if (flushE) begin
            e_q <= '0;
        end else if (!md_busy) begin
            e_q <= dec;
        end
    end

    assign regWriteE    = e_q.reg_write;
    assign memWriteE    = e_q.mem_write;
    assign ALUSrcE      = e_q.alu_src;
    assign resultSrcE   = e_q.result_src;
    assign jumpE        = e_q.jump;
    assign branchE      = e_q.branch;
    assign branchValidE = e_q.branch_valid;
    assign ALUControlE  = ALUC_W'(e_q.alu);
    assign illegalE     = e_q.illegal;

    // ------------------------------------------------------------------
    // M-op latency sequencer
    // ------------------------------------------------------------------
`ifdef MULDIV_EN
    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } seq_state_t;

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             md_multi;

    // Single-cycle variants never need to hold E.
    assign md_multi = dec_md && (func3[2] ? (DIV_LAT > 1) : (MUL_LAT > 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Count holds the remaining hold cycles; E is occupied for the loading
    // cycle's successor plus LAT-1 BUSY cycles... i.e. LAT cycles in total,
    // the last of them with the sequencer already back in IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flushE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (state == S_BUSY) begin
            cnt_nxt = cnt - 1'b1;
            if (cnt_nxt == '0) begin
                state_nxt = S_IDLE;
            end
        end else if (md_multi) begin
            state_nxt = S_BUSY;
            cnt_nxt   = func3[2] ? DIV_CNT : MUL_CNT;
        end
    end

    assign md_busy = (state == S_BUSY);
    assign mdStall = md_busy;
`else
    assign md_busy = 1'b0;
    assign mdStall = 1'b0;
`endif

endmodule

// File: doc/riscv_pipe_controller.md
Name: riscv_pipe_controller

Overview:
- Parametrised successor to the single-cycle decode controller of the pipelined RV32I core.
- Decodes op/func3/func7 in the D stage and registers all control into the ID/EX (E-stage) control register.
- Handles flush bubbles and flags illegal opcodes.
- Contains a latency sequencer that holds the E stage for multi-cycle M-extension ops and raises a stall toward the hazard unit.

Parameters:
- ALUC_W, 4, width of ALUControl; must be >= 4.
- MUL_LAT, 3, total E-stage cycles for MUL* ops; must be >= 1.
- DIV_LAT, 8, total E-stage cycles for DIV*/REM* ops; must be >= 1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- flushE  in  1  hazard unit: load bubble into the E register.
- immSrcD  out  3  immediate select, combinational: 000 I, 001 S, 010 B, 011 J, 100 U.
- regWriteE  out  1  registered.
- memWriteE  out  1  registered.
- ALUSrcE  out  1  registered; 1 selects the immediate.
- resultSrcE  out  2  registered: 00 ALU, 01 mem, 10 PC+4, 11 imm (lui).
- jumpE  out  2  registered: 00 none, 01 jal, 10 jalr.
- branchE  out  3  registered func3 of the branch.
- branchValidE  out  1  registered.
- ALUControlE  out  ALUC_W  registered.
- illegalE  out  1  registered illegal-instruction flag.
- mdStall  out  1  combinational; 1 while the M-op sequencer is holding E.

Behaviour:
- Reset (rst=0, async): all registered outputs 0; sequencer in IDLE with count 0; mdStall=0.
- Decode, by op:
  - 0110011 R-type:
    - func7=0000000: ALU op from func3.
    - func7=0100000 with func3=000 or 101: sub or sra.
    - func7=0000001: M op.
    - Any other func7: illegal.
  - 0010011 I-ALU: func7[5] is honoured only for func3=101 (srai).
  - 0000011 load: resultSrc=01, ALUSrc=1, ALU add.
  - 0100011 store: memWrite=1, imm S, ALU add.
  - 1100011 branch: branchValid=1, imm B, ALU sub.
  - 1101111 jal: jump=01, resultSrc=10, regWrite=1, imm J.
  - 1100111 jalr: jump=10, resultSrc=10, regWrite=1, ALUSrc=1.
  - 0110111 lui: resultSrc=11, regWrite=1, imm U.
- ALUControl encodings (low 4 bits, zero-extended to ALUC_W):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
  - 1010 mul family, 1011 div family; func3 for these is carried in branchE.
- Illegal op or func7:
  - E loads a bubble: all control 0, illegalE=1.
  - immSrcD=000.
- E-register update each rising edge, in priority order:
  1. flushE: load bubble with illegalE=0; sequencer forced to IDLE, count cleared. This aborts any in-flight M op.
  2. Sequencer BUSY: hold all E outputs.
  3. Otherwise: load decoded values.
- Sequencer:
  - IDLE -> BUSY on the edge that loads an M op with LAT>1, where LAT=MUL_LAT for func3[2]=0 and DIV_LAT for func3[2]=1; count loaded with LAT-1.
  - BUSY: count decrements each cycle; BUSY -> IDLE on the edge where count reaches 0.
  - LAT=1: no BUSY entry, mdStall never asserts.
- mdStall = (state==BUSY).
  - The hazard unit stalls F/D while mdStall=1.
  - The M op occupies E for exactly LAT cycles.
  - The instruction held in D loads on the edge after the last BUSY cycle.
- flushE during BUSY: mdStall drops the cycle after the edge.
- Reset during BUSY: immediate IDLE, outputs 0.

Optional Feature:
- MULDIV_EN:
  - Defined: M-extension decode and sequencer present as above.
  - Undefined:
    - op=0110011 with func7=0000001 decodes as illegal.
    - Sequencer logic is not generated; mdStall tied 0.
    - ALUControl codes 1010/1011 are never produced.

Test Plan:
- Reset: rst=0 mid-stream -> all E outputs 0 asynchronously; rst=1, then add (op 0110011, f3 000, f7 0) -> next edge regWriteE=1, ALUControlE=0000, ALUSrcE=0.
- Load then store then branch beq -> resultSrcE=01 / memWriteE=1 / branchValidE=1, branchE=000, ALUControlE=0001; immSrcD = 000, 001, 010.
- Illegal: op=1111111 -> illegalE=1, regWriteE=0, memWriteE=0; R-type with f7=0100000, f3=010 -> illegalE=1.
- MULDIV_EN, DIV_LAT=8: div (f7 0000001, f3 100), then add -> mdStall high exactly 7 cycles; ALUControlE=1011 for 8 cycles; add appears on the 9th.
- MULDIV_EN, MUL_LAT=3: mul, with flushE=1 on the 2nd E cycle -> next edge E is a bubble (all 0, illegalE=0); mdStall=0 from the following cycle.
- MULDIV_EN undefined: mul -> illegalE=1, mdStall stays 0.
